// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search helper for the AXI-Stream arbiter.
package axis_arb_pkg;

  localparam int TDATA_W = 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // First set bit of req searching upward from last+1, wrapping at n (n <= 64).
  // Scanned from the far end so the nearest requester overwrites the result.
  function automatic int rr_next(input logic [63:0] req, input int last, input int n);
    int idx;
    rr_next = last;
    for (int i = 64; i >= 1; i--) begin
      if (i <= n) begin
        idx = (last + i) % n;
        if (req[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered outputs, upstream ready is a flop (no comb path from i_ready).
module axis_skid_buffer #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;

  assign o_ready = !skid_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      skid_valid <= 1'b0;
    end else if (!o_valid || i_ready) begin
      // Output slot frees up: drain the skid entry first to keep beat order.
      if (skid_valid) begin
        o_data     <= skid_data;
        o_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        o_data  <= i_data;
        o_valid <= i_valid;
      end
    end else if (i_valid && !skid_valid) begin
      skid_data  <= i_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: a grant is held until the granted source's tlast beat.
// Define AXIS_ARB_OUTREG_EN to register the sink side through a 2-entry skid buffer.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SOURCES = 4,
  localparam int GNT_W       = $clog2(NUM_SOURCES)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [TDATA_W*NUM_SOURCES-1:0] i_tdata,
  input  logic [NUM_SOURCES-1:0]         i_tlast,
  input  logic [NUM_SOURCES-1:0]         i_tvalid,
  output logic [NUM_SOURCES-1:0]         o_tready,
  output logic [TDATA_W-1:0]             o_tdata,
  output logic                           o_tlast,
  output logic                           o_tvalid,
  input  logic                           i_tready,
  output logic [NUM_SOURCES-1:0]         o_grant
);

  state_e                              state;
  logic [GNT_W-1:0]                    gnt;
  logic [GNT_W-1:0]                    last;
  logic [NUM_SOURCES-1:0][TDATA_W-1:0] src_data;
  logic                                busy;
  logic                                m_tvalid;
  logic                                m_tlast;
  logic                                m_tready;
  logic [TDATA_W-1:0]                  m_tdata;

  assign src_data = i_tdata;

  // Gating with i_rst keeps the sink quiet during the reset cycle itself.
  assign busy     = (state == BUSY) && !i_rst;
  assign m_tvalid = busy && i_tvalid[gnt];
  assign m_tlast  = busy && i_tlast[gnt];
  assign m_tdata  = busy ? src_data[gnt] : '0;

  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_src
    assign o_grant[k]  = busy && (gnt == GNT_W'(k));
    assign o_tready[k] = o_grant[k] && m_tready;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= GNT_W'(NUM_SOURCES - 1);
    end else begin
      case (state)
        IDLE: if (|i_tvalid) begin
          gnt   <= GNT_W'(rr_next(64'(i_tvalid), int'(last), NUM_SOURCES));
          state <= BUSY;
        end
        BUSY: if (m_tvalid && m_tready && m_tlast) begin
          last  <= gnt;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_ARB_OUTREG_EN
  logic [TDATA_W:0] out_q;

  axis_skid_buffer #(.W(TDATA_W + 1)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  ({m_tlast, m_tdata}),
    .i_valid (m_tvalid),
    .o_ready (m_tready),
    .o_data  (out_q),
    .o_valid (o_tvalid),
    .i_ready (i_tready)
  );

  assign {o_tlast, o_tdata} = out_q;
`else
  assign m_tready = i_tready;
  assign o_tdata  = m_tdata;
  assign o_tlast  = m_tlast;
  assign o_tvalid = m_tvalid;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter (default combinational build, 4 sources).
module tb_axis_rr_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_tdata;
  logic [3:0]  i_tlast, i_tvalid, o_tready, o_grant;
  logic [7:0]  o_tdata;
  logic        o_tlast, o_tvalid, i_tready;

  axis_rr_arbiter #(.NUM_SOURCES(4)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready),
    .o_grant  (o_grant)
  );

  always #5 clk = ~clk;

  // Per-source message stores {last, data}, sink beat log.
  logic [8:0] src_mem [4][16];
  int         src_rd [4];
  int         src_wr [4];
  logic [3:0] stall;
  logic       rst_v, rdy_v;
  logic [7:0] lg_data [64];
  logic       lg_last [64];
  logic [3:0] lg_gnt  [64];
  int         lg_cyc  [64];
  int         lg_n, cyc;
  int         n_checks = 0, n_fail = 0;

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k]] = {l, d};
    src_wr[k]++;
  endtask

  task automatic drive();
    i_rst    = rst_v;
    i_tready = rdy_v;
    for (int k = 0; k < 4; k++) begin
      if (src_rd[k] < src_wr[k] && !stall[k]) begin
        {i_tlast[k], i_tdata[8*k +: 8]} = src_mem[k][src_rd[k]];
        i_tvalid[k] = 1'b1;
      end else begin
        i_tlast[k]        = 1'b0;
        i_tdata[8*k +: 8] = 8'h00;
        i_tvalid[k]       = 1'b0;
      end
    end
  endtask

  // One cycle: drive after the edge, then sample, log sink beats and retire accepted source beats.
  task automatic tick();
    @(posedge clk);
    #1 drive();
    #2;
    cyc++;
    if (o_tvalid && i_tready && lg_n < 64) begin
      lg_data[lg_n] = o_tdata;
      lg_last[lg_n] = o_tlast;
      lg_gnt[lg_n]  = o_grant;
      lg_cyc[lg_n]  = cyc;
      lg_n++;
    end
    for (int k = 0; k < 4; k++)
      if (o_tready[k] && i_tvalid[k]) src_rd[k]++;
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < 4; k++) begin
      src_rd[k] = 0;
      src_wr[k] = 0;
    end
    stall = 4'b0;
    rdy_v = 1'b1;
  endtask

  task automatic do_reset();
    clear_srcs();
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    lg_n  = 0;
  endtask

  task automatic test_reset();
    clear_srcs();
    for (int k = 0; k < 4; k++) push(k, 8'(8'hC0 + k), 1'b1);
    rst_v = 1'b1;
    tick();
    if (o_tvalid !== 1'b0) begin $display("FAIL rst_tvalid got %b want 0", o_tvalid); n_fail++; end
    n_checks++;
    if (o_tready !== 4'b0) begin $display("FAIL rst_tready got %b want 0000", o_tready); n_fail++; end
    n_checks++;
    if (o_grant !== 4'b0) begin $display("FAIL rst_grant got %b want 0000", o_grant); n_fail++; end
    n_checks++;
    if (o_tdata !== 8'h00) begin $display("FAIL rst_tdata got %h want 00", o_tdata); n_fail++; end
    n_checks++;
    if (o_tlast !== 1'b0) begin $display("FAIL rst_tlast got %b want 0", o_tlast); n_fail++; end
    n_checks++;
    rst_v = 1'b0;
    tick();
    if (o_tvalid !== 1'b0 || o_grant !== 4'b0) begin
      $display("FAIL idle_bubble got valid=%b grant=%b want 0/0000", o_tvalid, o_grant); n_fail++;
    end
    n_checks++;
    tick();
    if (o_grant !== 4'b0001 || o_tdata !== 8'hC0) begin
      $display("FAIL first_priority got grant=%b data=%h want 0001/c0", o_grant, o_tdata); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_single_source();
    int c0;
    do_reset();
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    c0 = cyc;
    repeat (5) tick();
    if (o_grant !== 4'b0 || o_tvalid !== 1'b0) begin
      $display("FAIL single_release got grant=%b valid=%b want 0000/0", o_grant, o_tvalid); n_fail++;
    end
    n_checks++;
    if (lg_n !== 3) begin $display("FAIL single_count got %0d want 3", lg_n); n_fail++; end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      if (lg_data[i] !== 8'(8'h41 + i) || lg_gnt[i] !== 4'b0100 || lg_cyc[i] !== c0 + 2 + i
          || lg_last[i] !== (i == 2)) begin
        $display("FAIL single_beat%0d got data=%h gnt=%b cyc=%0d last=%b want %h/0100/%0d/%b",
                 i, lg_data[i], lg_gnt[i], lg_cyc[i], lg_last[i], 8'(8'h41 + i), c0 + 2 + i, i == 2);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(k, 8'(k * 16), 1'b0);
      push(k, 8'(k * 16 + 1), 1'b1);
    end
    repeat (14) tick();
    if (lg_n !== 8) begin $display("FAIL simul_count got %0d want 8", lg_n); n_fail++; end
    n_checks++;
    for (int i = 0; i < 8; i++) begin
      if (lg_data[i] !== 8'((i / 2) * 16 + i % 2) || lg_gnt[i] !== 4'(1 << (i / 2))) begin
        $display("FAIL simul_beat%0d got data=%h gnt=%b want %h/%b",
                 i, lg_data[i], lg_gnt[i], 8'((i / 2) * 16 + i % 2), 4'(1 << (i / 2)));
        n_fail++;
      end
      n_checks++;
      if (i > 0) begin
        if (lg_cyc[i] - lg_cyc[i-1] !== ((i % 2) ? 1 : 2)) begin
          $display("FAIL simul_gap%0d got %0d want %0d", i, lg_cyc[i] - lg_cyc[i-1], (i % 2) ? 1 : 2);
          n_fail++;
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_fairness();
    int j, src;
    do_reset();
    for (int m = 0; m < 3; m++)
      for (int b = 0; b < 3; b++) begin
        push(1, 8'(16 + m * 4 + b), b == 2);
        push(3, 8'(48 + m * 4 + b), b == 2);
      end
    repeat (30) tick();
    if (lg_n !== 18) begin $display("FAIL fair_count got %0d want 18", lg_n); n_fail++; end
    n_checks++;
    for (int i = 0; i < 18; i++) begin
      j   = i / 3;
      src = (j % 2) ? 3 : 1;
      if (lg_data[i] !== 8'(src * 16 + (j / 2) * 4 + i % 3) || lg_gnt[i] !== 4'(1 << src)
          || lg_last[i] !== (i % 3 == 2)) begin
        $display("FAIL fair_beat%0d got data=%h gnt=%b last=%b want %h/%b/%b", i, lg_data[i],
                 lg_gnt[i], lg_last[i], 8'(src * 16 + (j / 2) * 4 + i % 3), 4'(1 << src), i % 3 == 2);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int b = 0; b < 4; b++) push(0, 8'(8'hA0 + b), b == 3);
    tick();
    tick();
    rdy_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_tdata !== 8'hA1 || o_tvalid !== 1'b1 || o_tready !== 4'b0 || o_grant !== 4'b0001) begin
        $display("FAIL bp_hold%0d got data=%h valid=%b ready=%b grant=%b want a1/1/0000/0001",
                 c, o_tdata, o_tvalid, o_tready, o_grant);
        n_fail++;
      end
      n_checks++;
    end
    rdy_v = 1'b1;
    repeat (6) tick();
    if (lg_n !== 4) begin $display("FAIL bp_count got %0d want 4", lg_n); n_fail++; end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      if (lg_data[i] !== 8'(8'hA0 + i)) begin
        $display("FAIL bp_beat%0d got %h want %h", i, lg_data[i], 8'(8'hA0 + i)); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_source_stall();
    logic [7:0] exp_d [6];
    logic [3:0] exp_g [6];
    exp_d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1};
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    for (int b = 0; b < 4; b++) push(1, 8'(8'hB0 + b), b == 3);
    tick();
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b1);
    tick();
    tick();
    stall = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_tvalid !== 1'b0 || o_grant !== 4'b0010 || o_tready[0] !== 1'b0) begin
        $display("FAIL stall%0d got valid=%b grant=%b ready=%b want 0/0010/xxx0",
                 c, o_tvalid, o_grant, o_tready);
        n_fail++;
      end
      n_checks++;
    end
    stall = 4'b0;
    repeat (8) tick();
    if (lg_n !== 6) begin $display("FAIL stall_count got %0d want 6", lg_n); n_fail++; end
    n_checks++;
    for (int i = 0; i < 6; i++) begin
      if (lg_data[i] !== exp_d[i] || lg_gnt[i] !== exp_g[i]) begin
        $display("FAIL stall_beat%0d got data=%h gnt=%b want %h/%b",
                 i, lg_data[i], lg_gnt[i], exp_d[i], exp_g[i]);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [7:0] exp_d [5];
    exp_d = '{8'h80, 8'h81, 8'h90, 8'h71, 8'h72};
    do_reset();
    push(0, 8'h60, 1'b1);
    tick();
    tick();
    push(3, 8'h70, 1'b0); push(3, 8'h71, 1'b0); push(3, 8'h72, 1'b1);
    tick();
    tick();
    rst_v = 1'b1;
    push(0, 8'h80, 1'b0); push(0, 8'h81, 1'b1); push(1, 8'h90, 1'b1);
    tick();
    if (o_tvalid !== 1'b0 || o_tready !== 4'b0) begin
      $display("FAIL midrst_during got valid=%b ready=%b want 0/0000", o_tvalid, o_tready); n_fail++;
    end
    n_checks++;
    rst_v = 1'b0;
    n0 = lg_n;
    tick();
    if (o_tvalid !== 1'b0 || o_tready !== 4'b0 || o_grant !== 4'b0) begin
      $display("FAIL midrst_after got valid=%b ready=%b grant=%b want 0/0000/0000",
               o_tvalid, o_tready, o_grant);
      n_fail++;
    end
    n_checks++;
    tick();
    if (o_grant !== 4'b0001 || o_tdata !== 8'h80) begin
      $display("FAIL midrst_regrant got grant=%b data=%h want 0001/80", o_grant, o_tdata); n_fail++;
    end
    n_checks++;
    repeat (10) tick();
    if (lg_n - n0 !== 5) begin $display("FAIL midrst_count got %0d want 5", lg_n - n0); n_fail++; end
    n_checks++;
    for (int i = 0; i < 5; i++) begin
      if (lg_data[n0 + i] !== exp_d[i]) begin
        $display("FAIL midrst_beat%0d got %h want %h", i, lg_data[n0 + i], exp_d[i]); n_fail++;
      end
      n_checks++;
    end
  endtask

  initial begin
    cyc  = 0;
    lg_n = 0;
    rst_v = 1'b1;
    clear_srcs();
    drive();
    test_reset();
    test_single_source();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_source_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of test");
    $fatal(1, "watchdog");
  end

endmodule
